// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a valid/ready byte stream into big-endian
// 32-bit words and issues one word-aligned write per word into instruction memory.
module instr_mem_loader #(
    parameter int          INSTR_WIDTH   = 32,
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          MEM_DEPTH     = 100,
    parameter int unsigned BASE_ADDRESS  = 0,
    parameter int          COUNT_WIDTH   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     InStart,
    input  logic [COUNT_WIDTH-1:0]   InWordCount,
    input  logic                     InByteValid,
    input  logic [7:0]               InByte,
    output logic                     OutByteReady,
    output logic                     OutWrEn,
    output logic [ADDRESS_WIDTH-1:0] OutWrAddress,
    output logic [INSTR_WIDTH-1:0]   OutWrData,
    output logic                     OutBusy,
    output logic                     OutDone,
    output logic                     OutError
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE  = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH = ADDRESS_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [COUNT_WIDTH-1:0]   count;
    logic [1:0]               byte_idx;
    logic [INSTR_WIDTH-1:0]   shift;
    logic                     err;
    logic                     take;
    logic                     in_range;
    logic [ADDRESS_WIDTH-1:0] word_idx;

    assign take     = (state == RECV) && InByteValid;
    assign word_idx = (addr - BASE) >> 2;
    assign in_range = word_idx < DEPTH;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (InStart) begin
                    state_nxt = (InWordCount == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (take && (byte_idx == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!in_range || (count == COUNT_WIDTH'(1))) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RECV;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: word count, address, byte packing and sticky error flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr     <= '0;
            count    <= '0;
            byte_idx <= '0;
            shift    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InStart) begin
                        err <= 1'b0;
                        if (InWordCount != '0) begin
                            count    <= InWordCount;
                            addr     <= BASE;
                            byte_idx <= '0;
                        end
                    end
                end
                RECV: begin
                    if (take) begin
                        shift    <= {shift[INSTR_WIDTH-9:0], InByte};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    addr     <= addr + ADDRESS_WIDTH'(4);
                    count    <= count - COUNT_WIDTH'(1);
                    byte_idx <= '0;
                    if (!in_range) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        OutByteReady = 1'b0;
        OutWrEn      = 1'b0;
        OutBusy      = 1'b0;
        OutDone      = 1'b0;
        case (state)
            RECV: begin
                OutByteReady = 1'b1;
                OutBusy      = 1'b1;
            end
            WRITE: begin
                OutBusy = 1'b1;
                OutWrEn = in_range;
            end
            DONE: begin
                OutDone = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign OutWrAddress = addr;
    assign OutWrData    = shift;
    assign OutError     = err;

endmodule
